wb_master_arbiter: RTL and testbench

//  Shares the SoC's single Wishbone master port (wb_intercon "io" port) between two bus masters:
//   - m0: the core's wishbone_controller.
//   - m1: a secondary master (boot copier / DMA / debug).

---
 rtl/wb_arb_pkg.sv | 23 ++
 rtl/wb_arb_watchdog.sv | 49 ++++
 rtl/wb_master_arbiter.sv | 136 +++++++++++++
 tb/tb_wb_master_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM states and the master-to-slave payload.
package wb_arb_pkg;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_M0   = 2'd1,
    ARB_M1   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic [SEL_W-1:0] sel;
    logic             we;
    logic             cyc;
    logic             stb;
  } wb_m2s_t;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus watchdog: counts unanswered strobe cycles, pulses expire, keeps a sticky timeout flag.
module wb_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic busy,
  input  logic done,
  output logic expire,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic             expire_q;
  logic             timeout_q;

  // Count only while a strobe waits unanswered; any pause or answer restarts the window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      expire_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (busy && !done) begin
        if (count_q == LAST) begin
          count_q  <= '0;
          expire_q <= 1'b1;
        end else begin
          count_q  <= count_q + CNT_W'(1);
          expire_q <= 1'b0;
        end
      end else begin
        count_q  <= '0;
        expire_q <= 1'b0;
      end
      // A late answer landing in the expiry cycle wins over the timeout.
      if (expire_q && !done) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign expire  = expire_q;
  assign timeout = timeout_q;

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter with cycle-locked grants and a hung-slave watchdog.
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned FIXED_PRIO     = 0,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;   // 1: m1 owned the bus most recently
  logic       req0, req1;
  logic       own0, own1;
  logic       expire;
  wb_m2s_t    m0_req, m1_req, own_req;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Grant is held for the whole cycle; on release the other master takes over directly.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (req0 && (!req1 || (FIXED_PRIO != 0) || last_q)) begin
          state_d = ARB_M0;
        end else if (req1) begin
          state_d = ARB_M1;
        end
      end
      ARB_M0: begin
        if (!m0_cyc_i) begin
          state_d = req1 ? ARB_M1 : ARB_IDLE;
        end
      end
      ARB_M1: begin
        if (!m1_cyc_i) begin
          state_d = req0 ? ARB_M0 : ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (state_d == ARB_M0) begin
      last_d = 1'b0;
    end else if (state_d == ARB_M1) begin
      last_d = 1'b1;
    end
  end

  assign m0_req = {m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i};
  assign m1_req = {m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i};

  always_comb begin
    own_req = '0;
    case (state_q)
      ARB_M0:  own_req = m0_req;
      ARB_M1:  own_req = m1_req;
      default: own_req = '0;
    endcase
  end

  assign own0 = (state_q == ARB_M0);
  assign own1 = (state_q == ARB_M1);

  assign s_adr_o = own_req.adr;
  assign s_dat_o = own_req.dat;
  assign s_sel_o = own_req.sel;
  assign s_we_o  = own_req.we;
  assign s_cyc_o = own_req.cyc;
  assign s_stb_o = own_req.stb & ~expire;

  // Only the owner sees ack/err; a forced err is dropped if the slave answers in the same cycle.
  assign m0_ack_o = own0 & s_ack_i;
  assign m1_ack_o = own1 & s_ack_i;
  assign m0_err_o = own0 & (s_err_i | (expire & s_cyc_o & ~s_ack_i));
  assign m1_err_o = own1 & (s_err_i | (expire & s_cyc_o & ~s_ack_i));
  assign m0_dat_o = (state_q != ARB_IDLE) ? s_dat_i : '0;
  assign m1_dat_o = (state_q != ARB_IDLE) ? s_dat_i : '0;
  assign grant_o  = {own1, own0};

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .busy   (s_cyc_o & s_stb_o),
    .done   (s_ack_i | s_err_i),
    .expire (expire),
    .timeout(timeout_o)
  );

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: round-robin instance (timeout 8) plus a fixed-priority twin.
module tb_wb_master_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i, s_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
  logic        s_ack_i, s_err_i;

  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, timeout_o;
  logic [1:0]  grant_o;

  logic [31:0] f_m0_dat_o, f_m1_dat_o, f_s_adr_o, f_s_dat_o;
  logic        f_m0_ack_o, f_m0_err_o, f_m1_ack_o, f_m1_err_o;
  logic [3:0]  f_s_sel_o;
  logic        f_s_we_o, f_s_cyc_o, f_s_stb_o, f_timeout_o;
  logic [1:0]  f_grant_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_master_arbiter #(.TIMEOUT_CYCLES(8), .FIXED_PRIO(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .grant_o(grant_o), .timeout_o(timeout_o)
  );

  wb_master_arbiter #(.TIMEOUT_CYCLES(8), .FIXED_PRIO(1)) dut_fixed (
    .clk(clk), .reset_n(reset_n),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(f_m0_dat_o), .m0_ack_o(f_m0_ack_o),
    .m0_err_o(f_m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(f_m1_dat_o), .m1_ack_o(f_m1_ack_o),
    .m1_err_o(f_m1_err_o),
    .s_adr_o(f_s_adr_o), .s_dat_o(f_s_dat_o), .s_sel_o(f_s_sel_o), .s_we_o(f_s_we_o),
    .s_cyc_o(f_s_cyc_o), .s_stb_o(f_s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .grant_o(f_grant_o), .timeout_o(f_timeout_o)
  );

  task automatic idle_inputs();
    m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clk); #1;
    checks++;
    if ({grant_o, s_cyc_o, s_stb_o, timeout_o, m0_ack_o, m1_ack_o} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 0000000",
                         {grant_o, s_cyc_o, s_stb_o, timeout_o, m0_ack_o, m1_ack_o});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (grant_o !== 2'b00) begin
      errors++; $display("FAIL reset_idle_grant: got %b want 00", grant_o);
    end
  endtask

  task automatic test_single_master();
    @(negedge clk);
    m0_adr_i = 32'h0000_1000; m0_sel_i = 4'hF; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    #1;
    checks++;
    if (s_stb_o !== 1'b0) begin
      errors++; $display("FAIL single_stb_early: got %b want 0", s_stb_o);
    end
    @(negedge clk); #1;
    checks++;
    if ({s_cyc_o, s_stb_o, grant_o, s_adr_o} !== {2'b11, 2'b01, 32'h0000_1000}) begin
      errors++; $display("FAIL single_grant: got cyc/stb=%b%b grant=%b adr=%h want 11 01 00001000",
                         s_cyc_o, s_stb_o, grant_o, s_adr_o);
    end
    repeat (2) begin
      @(negedge clk); #1;
      checks++;
      if (m0_ack_o !== 1'b0) begin
        errors++; $display("FAIL single_no_early_ack: got %b want 0", m0_ack_o);
      end
    end
    @(negedge clk);
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({m0_ack_o, m1_ack_o, m0_dat_o} !== {2'b10, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL single_ack: got ack0=%b ack1=%b dat=%h want 1 0 deadbeef",
                         m0_ack_o, m1_ack_o, m0_dat_o);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (s_cyc_o !== 1'b0) begin
      errors++; $display("FAIL single_cyc_drop: got %b want 0", s_cyc_o);
    end
    @(negedge clk); #1;
    checks++;
    if (grant_o !== 2'b00) begin
      errors++; $display("FAIL single_release: got %b want 00", grant_o);
    end
  endtask

  task automatic test_tie();
    logic [1:0] exp_rr [3];
    exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01;
    apply_reset();
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (grant_o !== exp_rr[r]) begin
        errors++; $display("FAIL tie_rr_grant round %0d: got %b want %b", r, grant_o, exp_rr[r]);
      end
      checks++;
      if (f_grant_o !== 2'b01) begin
        errors++; $display("FAIL tie_fixed_grant round %0d: got %b want 01", r, f_grant_o);
      end
      @(negedge clk);
      s_ack_i = 1'b1;
      #1;
      checks++;
      if ({m1_ack_o, m0_ack_o} !== exp_rr[r]) begin
        errors++; $display("FAIL tie_ack_owner round %0d: got %b want %b", r, {m1_ack_o, m0_ack_o}, exp_rr[r]);
      end
      @(negedge clk);
      idle_inputs();
      @(negedge clk); #1;
      checks++;
      if ({grant_o, f_grant_o} !== 4'b0000) begin
        errors++; $display("FAIL tie_idle round %0d: got %b/%b want 00/00", r, grant_o, f_grant_o);
      end
    end
  endtask

  task automatic test_lock();
    @(negedge clk);
    m0_adr_i = 32'h10; m0_dat_i = 32'h1; m0_sel_i = 4'hF; m0_we_i = 1'b1;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    @(negedge clk);
    m1_adr_i = 32'h20; m1_sel_i = 4'hF; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    #1;
    checks++;
    if ({grant_o, s_we_o, s_adr_o, s_dat_o} !== {2'b01, 1'b1, 32'h10, 32'h1}) begin
      errors++; $display("FAIL lock_write1: got grant=%b we=%b adr=%h dat=%h want 01 1 10 1",
                         grant_o, s_we_o, s_adr_o, s_dat_o);
    end
    @(negedge clk);
    s_ack_i = 1'b1;
    #1;
    checks++;
    if ({m0_ack_o, m1_ack_o} !== 2'b10) begin
      errors++; $display("FAIL lock_ack1: got %b%b want 10", m0_ack_o, m1_ack_o);
    end
    @(negedge clk);
    s_ack_i = 1'b0; m0_adr_i = 32'h14; m0_dat_i = 32'h2;
    #1;
    checks++;
    if ({grant_o, s_adr_o, s_dat_o} !== {2'b01, 32'h14, 32'h2}) begin
      errors++; $display("FAIL lock_write2: got grant=%b adr=%h dat=%h want 01 14 2",
                         grant_o, s_adr_o, s_dat_o);
    end
    @(negedge clk);
    s_ack_i = 1'b1;
    #1;
    checks++;
    if ({m0_ack_o, m1_ack_o} !== 2'b10) begin
      errors++; $display("FAIL lock_ack2: got %b%b want 10", m0_ack_o, m1_ack_o);
    end
    @(negedge clk);
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
    #1;
    checks++;
    if ({grant_o, s_cyc_o} !== 3'b010) begin
      errors++; $display("FAIL lock_release: got grant=%b cyc=%b want 01 0", grant_o, s_cyc_o);
    end
    @(negedge clk);
    s_ack_i = 1'b1;
    #1;
    checks++;
    if ({grant_o, s_cyc_o, s_adr_o, m1_ack_o, m0_ack_o} !== {2'b10, 1'b1, 32'h20, 2'b10}) begin
      errors++; $display("FAIL lock_handover: got grant=%b cyc=%b adr=%h ack1=%b ack0=%b want 10 1 20 1 0",
                         grant_o, s_cyc_o, s_adr_o, m1_ack_o, m0_ack_o);
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_race();
    @(negedge clk);
    m0_adr_i = 32'h40; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      checks++;
      if ({s_stb_o, m0_err_o} !== 2'b10) begin
        errors++; $display("FAIL race_wait cycle %0d: got stb=%b err=%b want 1 0", k, s_stb_o, m0_err_o);
      end
    end
    @(negedge clk);
    s_ack_i = 1'b1; s_dat_i = 32'hCAFE_0001;
    #1;
    checks++;
    if ({m0_ack_o, m0_err_o, s_stb_o, m0_dat_o} !== {3'b100, 32'hCAFE_0001}) begin
      errors++; $display("FAIL race_ack: got ack=%b err=%b stb=%b dat=%h want 1 0 0 cafe0001",
                         m0_ack_o, m0_err_o, s_stb_o, m0_dat_o);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (timeout_o !== 1'b0) begin
      errors++; $display("FAIL race_timeout_flag: got %b want 0", timeout_o);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    @(negedge clk);
    m1_adr_i = 32'h8000_0000; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({grant_o, s_stb_o} !== 3'b101) begin
      errors++; $display("FAIL timeout_start: got grant=%b stb=%b want 10 1", grant_o, s_stb_o);
    end
    for (int k = 1; k < 8; k++) begin
      @(negedge clk); #1;
      checks++;
      if ({s_stb_o, m1_err_o, timeout_o} !== 3'b100) begin
        errors++; $display("FAIL timeout_wait cycle %0d: got stb=%b err=%b to=%b want 1 0 0",
                           k, s_stb_o, m1_err_o, timeout_o);
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({m1_err_o, m0_err_o, s_stb_o, m1_ack_o} !== 4'b1000) begin
      errors++; $display("FAIL timeout_err: got err1=%b err0=%b stb=%b ack1=%b want 1 0 0 0",
                         m1_err_o, m0_err_o, s_stb_o, m1_ack_o);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if ({timeout_o, m1_err_o} !== 2'b10) begin
      errors++; $display("FAIL timeout_sticky: got to=%b err=%b want 1 0", timeout_o, m1_err_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    m1_adr_i = 32'h300; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({grant_o, s_stb_o} !== 3'b101) begin
      errors++; $display("FAIL rstmid_pre: got grant=%b stb=%b want 10 1", grant_o, s_stb_o);
    end
    @(negedge clk);
    reset_n = 1'b0; s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
    #1;
    checks++;
    if ({s_cyc_o, s_stb_o, grant_o, m1_ack_o, m1_err_o, timeout_o, m1_dat_o} !== 39'b0) begin
      errors++; $display("FAIL rstmid_outputs: got cyc=%b stb=%b grant=%b ack=%b err=%b to=%b dat=%h want all 0",
                         s_cyc_o, s_stb_o, grant_o, m1_ack_o, m1_err_o, timeout_o, m1_dat_o);
    end
    @(negedge clk);
    reset_n = 1'b1; s_ack_i = 1'b0; s_dat_i = '0;
    m0_adr_i = 32'h500; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({grant_o, s_adr_o} !== {2'b01, 32'h500}) begin
      errors++; $display("FAIL rstmid_first_tie: got grant=%b adr=%h want 01 00000500", grant_o, s_adr_o);
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_master();
    test_tie();
    test_lock();
    test_race();
    test_timeout();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
